pipe_hold_ctrl: RTL

Pipeline hold/flush controller for the 3-stage core. It arbitrates redirect requests (branch/jump from EX, interrupt entry from CLINT) and stall requests (multi-cycle EX ops, bus arbiter, JTAG halt). It drives the shared `hold_flag` bus consumed by the PC, IF/ID and ID/EX stage registers, and the PC redirect. It also sequences post-redirect flush cycles, watches for bus stalls that never end, and counts stall cycles for performance monitoring.

---
 rtl/pipe_hold_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: arbitrates redirects and stall requests into the
// shared hold_flag bus, sequences post-redirect flush cycles, watches bus stalls and counts stall cycles.
module pipe_hold_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned BUS_TIMEOUT  = 256,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_req_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             int_assert_i,
  input  logic [31:0]      int_addr_i,
  input  logic             ex_hold_req_i,
  input  logic             rib_hold_req_i,
  input  logic             jtag_halt_req_i,
  output logic [2:0]       hold_flag_o,
  output logic             jump_flag_o,
  output logic [31:0]      jump_addr_o,
  output logic             flush_busy_o,
  output logic             bus_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [2:0]  HOLD_NONE  = 3'b000;
  localparam logic [2:0]  HOLD_PC    = 3'b001;
  localparam logic [2:0]  HOLD_ALL   = 3'b011;
  localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES);
  localparam logic [15:0] BUS_LIMIT  = 16'(BUS_TIMEOUT);
  localparam bit          HAS_FLUSH  = (FLUSH_CYCLES != 0);

  state_t           state, state_nxt;
  logic [3:0]       flush_cnt, flush_cnt_nxt;
  logic [15:0]      bus_cnt, bus_cnt_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             redirect;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    bus_cnt_nxt   = 16'd0;
    redirect      = int_assert_i | jump_req_i;

    case (state)
      RUN: begin
        if (redirect && HAS_FLUSH) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (redirect) begin
          flush_cnt_nxt = FLUSH_LOAD;
        end else if (flush_cnt == 4'd1) begin
          state_nxt     = RUN;
          flush_cnt_nxt = 4'd0;
        end else begin
          flush_cnt_nxt = flush_cnt - 4'd1;
        end
      end
      default: begin
        state_nxt     = RUN;
        flush_cnt_nxt = 4'd0;
      end
    endcase

    // Watchdog saturates so the timeout pulse fires once per continuous stall.
    if (rib_hold_req_i) begin
      bus_cnt_nxt = (bus_cnt == BUS_LIMIT) ? bus_cnt : bus_cnt + 16'd1;
    end

    // Interrupt wins; a simultaneous EX jump is dropped and flushed with the rest.
    jump_flag_o = redirect & ~rst;
    jump_addr_o = 32'd0;
    if (!rst) begin
      if (int_assert_i)    jump_addr_o = int_addr_i;
      else if (jump_req_i) jump_addr_o = jump_addr_i;
    end

    hold_flag_o = HOLD_NONE;
    if (!rst) begin
      if (redirect || state == FLUSH || ex_hold_req_i || jtag_halt_req_i) hold_flag_o = HOLD_ALL;
      else if (rib_hold_req_i)                                             hold_flag_o = HOLD_PC;
    end

    bus_timeout_o = ~rst & rib_hold_req_i & (bus_cnt == BUS_LIMIT - 16'd1);
    flush_busy_o  = ~rst & (state == FLUSH);
    stall_cnt_o   = rst ? '0 : stall_cnt;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= 4'd0;
      bus_cnt   <= 16'd0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      bus_cnt   <= bus_cnt_nxt;
      if (hold_flag_o != HOLD_NONE) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
